traffic_conflict_monitor: RTL and testbench
===========================================

TRAFFIC_CONFLICT_MONITOR -- requirements
Module: traffic_conflict_monitor

Interface
REQ-001 Parameter MIN_GREEN, default 8: minimum legal green dwell in clk cycles.
REQ-002 Parameter MIN_YELLOW, default 4: minimum legal yellow dwell in clk cycles.
REQ-003 Parameter MAX_PHASE, default 64: maximum legal dwell of any single lamp state in clk cycles.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ns_red, ns_yellow, ns_green  input  1 each  NS lamp drives from the controller.
REQ-007 ew_red, ew_yellow, ew_green  input  1 each  EW lamp drives from the controller.
REQ-008 clear_fault  input  1  one-cycle request to clear the latched fault.
REQ-009 fault  output  1  latched fault flag.
REQ-010 fault_code  output  3  code of the first latched fault.
REQ-011 flash_req  output  1  request to the controller for all-red flash mode; equals fault.
REQ-012 cycle_count  output  8  count of completed NS signal cycles.

Function
REQ-013 Lamps are sampled every cycle and decoded per direction to R, Y, G or BAD; BAD means not exactly one lamp is lit.
REQ-014 Fault codes: 0 none, 1 BAD lamp pattern, 2 conflict (neither direction R), 3 illegal transition, 4 yellow short, 5 green short, 6 stuck.
REQ-015 The legal transitions are G->Y, Y->R and R->G; any other change of decoded state raises code 3.
REQ-016 Each direction has a dwell counter: it resets to 1 on a state change, increments while the state is held, and saturates at MAX_PHASE.
REQ-017 Leaving Y with dwell < MIN_YELLOW raises code 4.
REQ-018 Leaving G with dwell < MIN_GREEN raises code 5.
REQ-019 Reaching dwell = MAX_PHASE in any state raises code 6.
REQ-020 After reset, the first decoded state of each direction is adopted without a transition check, and no dwell check applies to that first phase.
REQ-021 A violation sampled in cycle N asserts fault and flash_req, with fault_code loaded, at the clock edge ending cycle N (one-cycle latency).
REQ-022 If several codes are raised in the same cycle, in either direction, the lowest nonzero code wins.
REQ-023 Once fault = 1, later violations do not alter fault_code.
REQ-024 clear_fault = 1 with no violation in that cycle sets fault = 0 and fault_code = 0 at the next edge.
REQ-025 clear_fault = 1 coincident with a violation loads the new violation's code; the fault stays set.
REQ-026 Tracking and dwell counting continue while a fault is latched.
REQ-027 cycle_count increments on each NS Y->R transition and wraps from 255 to 0.

Reset
REQ-028 With rst_n low: fault = 0, fault_code = 0, flash_req = 0, cycle_count = 0, both directions in the UNKNOWN tracker state, both dwell counters = 0.
REQ-029 Reset asserted mid-phase or mid-fault overrides everything immediately; after release, tracking restarts per REQ-020.

Configuration
REQ-030 Macro TRAFFIC_MON_STATS_EN defined: cycle_count operates per REQ-027.
REQ-031 Macro TRAFFIC_MON_STATS_EN undefined: the cycle_count port exists and is tied to 0, and no counter register is built.

Structure
REQ-032 Shared package traffic_pkg holds the lamp-state enumeration (R, Y, G, BAD, UNKNOWN) and the fault-code constants.
REQ-033 Sub-module traffic_lamp_tracker is instantiated once per direction; it performs decode, dwell counting and the code 1/3/4/5/6 checks.
REQ-034 Conflict detection (code 2), priority selection, the fault latch and cycle_count are implemented in the top module.

Verification
REQ-035 Legal sequence with defaults (NS G 32, Y 4, R 20; EW R 36, G 16, Y 4) for 3 NS cycles -> fault = 0 throughout and cycle_count = 3.
REQ-036 NS G held 8 cycles, then NS R directly -> fault = 1 and fault_code = 3 one cycle after the first R sample.
REQ-037 NS Y held 2 cycles, then R -> fault_code = 4; subsequent NS G/Y both lit -> fault_code remains 4.
REQ-038 NS G and EW G lit together, with NS red and yellow also lit (codes 1 and 2 raised at once) -> fault_code = 1; clear_fault pulsed after lamps are restored to legal -> fault = 0 next edge.
REQ-039 EW R held 64 cycles -> fault_code = 6 at the 64th cycle; rst_n pulsed low -> all outputs 0 and no fault on the first post-reset sample.
REQ-040 Build without TRAFFIC_MON_STATS_EN, run REQ-035 stimulus -> cycle_count = 0 throughout.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the traffic conflict monitor: lamp-state enumeration, fault codes and helpers.
package traffic_pkg;

    typedef enum logic [2:0] {
        LampUnknown = 3'd0,
        LampR       = 3'd1,
        LampY       = 3'd2,
        LampG       = 3'd3,
        LampBad     = 3'd4
    } lamp_e;

    localparam logic [2:0] CodeNone        = 3'd0;
    localparam logic [2:0] CodeBad         = 3'd1;
    localparam logic [2:0] CodeConflict    = 3'd2;
    localparam logic [2:0] CodeIllegal     = 3'd3;
    localparam logic [2:0] CodeYellowShort = 3'd4;
    localparam logic [2:0] CodeGreenShort  = 3'd5;
    localparam logic [2:0] CodeStuck       = 3'd6;

    function automatic lamp_e decode_lamps(input logic red, input logic yellow,
                                           input logic green);
        unique case ({red, yellow, green})
            3'b100:  return LampR;
            3'b010:  return LampY;
            3'b001:  return LampG;
            default: return LampBad;
        endcase
    endfunction

    // Lowest nonzero code wins; zero means "no violation".
    function automatic logic [2:0] min_code(input logic [2:0] a, input logic [2:0] b);
        if (a == CodeNone) return b;
        if (b == CodeNone) return a;
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/traffic_lamp_tracker.sv
// Per-direction lamp decode, dwell counter and pattern/transition/dwell violation checks.
module traffic_lamp_tracker
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_GREEN  = 8,
    parameter int unsigned MIN_YELLOW = 4,
    parameter int unsigned MAX_PHASE  = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_red,
    input  logic       i_yellow,
    input  logic       i_green,
    output lamp_e      o_dec,
    output logic [2:0] o_code,
    output logic       o_y_to_r
);

    localparam int unsigned DW = $clog2(MAX_PHASE + 1);
    localparam logic [DW-1:0] MaxDwell  = DW'(MAX_PHASE);
    localparam logic [DW-1:0] MinGreen  = DW'(MIN_GREEN);
    localparam logic [DW-1:0] MinYellow = DW'(MIN_YELLOW);

    lamp_e         r_state;
    logic [DW-1:0] r_dwell;
    logic          r_first;

    lamp_e         w_dec;
    logic          w_adopt;
    logic          w_changed;
    logic          w_legal;
    logic [2:0]    w_code;

    assign w_dec     = decode_lamps(i_red, i_yellow, i_green);
    assign w_adopt   = (r_state == LampUnknown);
    assign w_changed = !w_adopt && (w_dec != r_state);
    assign w_legal   = ((r_state == LampG) && (w_dec == LampY)) ||
                       ((r_state == LampY) && (w_dec == LampR)) ||
                       ((r_state == LampR) && (w_dec == LampG));

    // Checks are applied highest code first so the lowest raised code is what remains.
    always_comb begin
        w_code = CodeNone;
        if (!w_adopt && !w_changed && (r_dwell == MaxDwell - 1'b1)) w_code = CodeStuck;
        if (w_changed && !r_first && (r_state == LampG) && (r_dwell < MinGreen))
            w_code = CodeGreenShort;
        if (w_changed && !r_first && (r_state == LampY) && (r_dwell < MinYellow))
            w_code = CodeYellowShort;
        if (w_changed && !w_legal) w_code = CodeIllegal;
        if (w_dec == LampBad) w_code = CodeBad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LampUnknown;
            r_dwell <= '0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_dec;
            if (w_adopt) begin
                r_dwell <= DW'(1);
                r_first <= 1'b1;
            end else if (w_changed) begin
                r_dwell <= DW'(1);
                r_first <= 1'b0;
            end else if (r_dwell != MaxDwell) begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    assign o_dec    = w_dec;
    assign o_code   = w_code;
    assign o_y_to_r = (r_state == LampY) && (w_dec == LampR);

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Intersection safety monitor: conflict check, fault latch and NS cycle counter.
// Optional statistics counter built only when TRAFFIC_MON_STATS_EN is defined.
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_GREEN  = 8,
    parameter int unsigned MIN_YELLOW = 4,
    parameter int unsigned MAX_PHASE  = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ns_red,
    input  logic       ns_yellow,
    input  logic       ns_green,
    input  logic       ew_red,
    input  logic       ew_yellow,
    input  logic       ew_green,
    input  logic       clear_fault,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash_req,
    output logic [7:0] cycle_count
);

    lamp_e      w_ns_dec;
    lamp_e      w_ew_dec;
    logic [2:0] w_ns_code;
    logic [2:0] w_ew_code;
    logic       w_ns_y_to_r;
    logic       w_unused_ew_y_to_r;
    logic [2:0] w_conflict_code;
    logic [2:0] w_code;

    logic       r_fault;
    logic [2:0] r_code;

    traffic_lamp_tracker #(
        .MIN_GREEN  (MIN_GREEN),
        .MIN_YELLOW (MIN_YELLOW),
        .MAX_PHASE  (MAX_PHASE)
    ) u_ns (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_red    (ns_red),
        .i_yellow (ns_yellow),
        .i_green  (ns_green),
        .o_dec    (w_ns_dec),
        .o_code   (w_ns_code),
        .o_y_to_r (w_ns_y_to_r)
    );

    traffic_lamp_tracker #(
        .MIN_GREEN  (MIN_GREEN),
        .MIN_YELLOW (MIN_YELLOW),
        .MAX_PHASE  (MAX_PHASE)
    ) u_ew (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_red    (ew_red),
        .i_yellow (ew_yellow),
        .i_green  (ew_green),
        .o_dec    (w_ew_dec),
        .o_code   (w_ew_code),
        .o_y_to_r (w_unused_ew_y_to_r)
    );

    assign w_conflict_code = ((w_ns_dec != LampR) && (w_ew_dec != LampR)) ? CodeConflict
                                                                          : CodeNone;
    assign w_code = min_code(min_code(w_ns_code, w_ew_code), w_conflict_code);

    // A clear coincident with a violation reloads the code instead of clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
            r_code  <= CodeNone;
        end else if (w_code != CodeNone) begin
            if (!r_fault || clear_fault) begin
                r_fault <= 1'b1;
                r_code  <= w_code;
            end
        end else if (clear_fault) begin
            r_fault <= 1'b0;
            r_code  <= CodeNone;
        end
    end

    assign fault      = r_fault;
    assign flash_req  = r_fault;
    assign fault_code = r_code;

`ifdef TRAFFIC_MON_STATS_EN
    logic [7:0] r_cycle_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_count <= 8'd0;
        end else if (w_ns_y_to_r) begin
            r_cycle_count <= r_cycle_count + 8'd1;
        end
    end

    assign cycle_count = r_cycle_count;
`else
    logic w_unused_ns_y_to_r;

    assign w_unused_ns_y_to_r = w_ns_y_to_r;
    assign cycle_count        = 8'd0;
`endif

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Scoreboard bench for traffic_conflict_monitor: directed lamp vectors push expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_traffic_conflict_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       clear_fault;
    logic       fault;
    logic [2:0] fault_code;
    logic       flash_req;
    logic [7:0] cycle_count;

    always #5 clk = ~clk;

    traffic_conflict_monitor u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ns_red      (ns[2]),
        .ns_yellow   (ns[1]),
        .ns_green    (ns[0]),
        .ew_red      (ew[2]),
        .ew_yellow   (ew[1]),
        .ew_green    (ew[0]),
        .clear_fault (clear_fault),
        .fault       (fault),
        .fault_code  (fault_code),
        .flash_req   (flash_req),
        .cycle_count (cycle_count)
    );

    localparam logic [2:0] R   = 3'b100;
    localparam logic [2:0] Y   = 3'b010;
    localparam logic [2:0] G   = 3'b001;
    localparam logic [2:0] RYG = 3'b111;
    localparam logic [2:0] YG  = 3'b011;

`ifdef TRAFFIC_MON_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        string      name;
        logic       f;
        logic [2:0] c;
        logic [7:0] n;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [7:0] ecnt(input int k);
        return STATS ? 8'(k) : 8'd0;
    endfunction

    task automatic push_exp(input string name, input logic f, input logic [2:0] c, input int k);
        exp_t e;
        e.name = name;
        e.f    = f;
        e.c    = c;
        e.n    = ecnt(k);
        q.push_back(e);
    endtask

    // Drive one lamp vector for n cycles; expect (f, c, k) after the last or every cycle.
    task automatic step(input string name, input logic [2:0] ns_v, input logic [2:0] ew_v,
                        input logic clr_v, input int n, input bit each, input logic f,
                        input logic [2:0] c, input int k);
        ns          = ns_v;
        ew          = ew_v;
        clear_fault = clr_v;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (each || i == n - 1) push_exp(name, f, c, k);
        end
        clear_fault = 1'b0;
    endtask

    task automatic do_reset(input string name);
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        ns          = R;
        ew          = R;
        clear_fault = 1'b0;
        push_exp(name, 1'b0, 3'd0, 0);
        repeat (2) @(posedge clk);
        #1;
        push_exp(name, 1'b0, 3'd0, 0);
        rst_n = 1'b1;
    endtask

    task automatic chk(input string name, input string field, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d at %0t", name, field, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "fault", int'(fault), int'(e.f));
            chk(e.name, "flash_req", int'(flash_req), int'(e.f));
            chk(e.name, "fault_code", int'(fault_code), int'(e.c));
            chk(e.name, "cycle_count", int'(cycle_count), int'(e.n));
        end
    end

    initial begin
        rst_n       = 1'b0;
        ns          = R;
        ew          = R;
        clear_fault = 1'b0;

        // Legal three-cycle sequence: no fault, NS Y->R counted each period.
        do_reset("rst_legal");
        for (int p = 1; p <= 3; p++) begin
            step("legal_ns_g", G, R, 1'b0, 32, 1'b1, 1'b0, 3'd0, p - 1);
            step("legal_ns_y", Y, R, 1'b0, 4, 1'b1, 1'b0, 3'd0, p - 1);
            step("legal_ew_g", R, G, 1'b0, 16, 1'b1, 1'b0, 3'd0, p);
            step("legal_ew_y", R, Y, 1'b0, 4, 1'b1, 1'b0, 3'd0, p);
        end

        // NS G directly to R is an illegal transition.
        do_reset("rst_illegal");
        step("illegal_g_hold", G, R, 1'b0, 8, 1'b1, 1'b0, 3'd0, 0);
        step("illegal_g_to_r", R, R, 1'b0, 1, 1'b0, 1'b1, 3'd3, 0);
        step("illegal_latched", R, R, 1'b0, 3, 1'b1, 1'b1, 3'd3, 0);

        // Short yellow, then a later BAD pattern must not overwrite the latched code.
        do_reset("rst_yshort");
        step("yshort_g", G, R, 1'b0, 10, 1'b0, 1'b0, 3'd0, 0);
        step("yshort_y", Y, R, 1'b0, 2, 1'b1, 1'b0, 3'd0, 0);
        step("yshort_to_r", R, R, 1'b0, 1, 1'b0, 1'b1, 3'd4, 1);
        step("yshort_sticky", YG, R, 1'b0, 2, 1'b1, 1'b1, 3'd4, 1);

        // BAD pattern with simultaneous conflict; clear; clear coincident with violation.
        do_reset("rst_bad");
        step("bad_g", G, R, 1'b0, 10, 1'b0, 1'b0, 3'd0, 0);
        step("bad_and_conflict", RYG, G, 1'b0, 1, 1'b0, 1'b1, 3'd1, 0);
        step("bad_restored", R, G, 1'b0, 3, 1'b1, 1'b1, 3'd1, 0);
        step("bad_clear", R, G, 1'b1, 1, 1'b0, 1'b0, 3'd0, 0);
        step("bad_cleared_hold", R, G, 1'b0, 2, 1'b1, 1'b0, 3'd0, 0);
        step("ew_g_to_r", R, R, 1'b0, 1, 1'b0, 1'b1, 3'd3, 0);
        step("clear_with_viol", G, Y, 1'b1, 1, 1'b0, 1'b1, 3'd2, 0);

        // EW red stuck for MAX_PHASE cycles, then reset mid-fault.
        do_reset("rst_stuck");
        step("stuck_ns_g", G, R, 1'b0, 20, 1'b0, 1'b0, 3'd0, 0);
        step("stuck_ns_y", Y, R, 1'b0, 4, 1'b0, 1'b0, 3'd0, 0);
        step("stuck_63", R, R, 1'b0, 39, 1'b0, 1'b0, 3'd0, 1);
        step("stuck_64", R, R, 1'b0, 1, 1'b0, 1'b1, 3'd6, 1);
        do_reset("rst_mid_fault");
        step("post_reset_first", G, R, 1'b0, 1, 1'b0, 1'b0, 3'd0, 0);

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
